conv: RTL and testbench

Streaming 3×3 two-dimensional convolution engine for the image-filter datapath.
- Loads a 3×3 signed kernel one column per cycle, then slides a 3×3 pixel window one column per valid cycle.
- Produces one fixed-point filtered sample per window position.
- Sits between the three line-buffer memories (`bram_memory` instances) and the result memory, controlled by GPIO from the host processor.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_if.sv | 26 ++
 rtl/bram_memory.sv | 33 +++
 rtl/conv_mac3x3.sv | 26 ++
 rtl/conv.sv | 49 ++++
 tb/tb_conv.sv | 229 ++++++++++++++++++++++
 6 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths and array types for the 3x3 convolution engine
// and its line/result memories.
//   BIT_LEN    - kernel coefficient / pixel width
//   CONV_LEN   - signed sum-of-products accumulator width
//   CONV_LPOS  - accumulator MSBs forwarded to the output sample
//   M_LEN      - kernel/window dimension (fixed at 3)
//   RAM_WIDTH  - output sample / memory word width (equals CONV_LPOS)
//   NB_ADDRESS - memory address width
package conv_pkg;

    localparam int BIT_LEN    = 8;
    localparam int CONV_LEN   = 20;
    localparam int CONV_LPOS  = 13;
    localparam int M_LEN      = 3;
    localparam int RAM_WIDTH  = 13;
    localparam int NB_ADDRESS = 10;

    // Q1.7 coefficient times 9-bit zero-extended pixel.
    localparam int PROD_LEN   = 2 * BIT_LEN + 1;

    typedef logic signed [BIT_LEN-1:0] coef_t;
    typedef logic        [BIT_LEN-1:0] pixel_t;

    // Both arrays are indexed [column][row]; column 0 is the oldest column,
    // row 0 is the top row.
    typedef coef_t  [M_LEN-1:0][M_LEN-1:0] kernel_t;
    typedef pixel_t [M_LEN-1:0][M_LEN-1:0] window_t;

endpackage

// File: rtl/conv_if.sv
// conv_if: column-stream bus into the convolution engine and its sample out.
//   i_dato0..2  - top/middle/bottom element of the incoming column
//   i_selecK_I  - 0 = kernel load, 1 = image
//   i_valid     - column strobe
//   o_data      - signed filtered sample
// master: column producer (host/line buffers); slave: conv.
interface conv_if;

    logic        [conv_pkg::BIT_LEN-1:0]   i_dato0;
    logic        [conv_pkg::BIT_LEN-1:0]   i_dato1;
    logic        [conv_pkg::BIT_LEN-1:0]   i_dato2;
    logic                                  i_selecK_I;
    logic                                  i_valid;
    logic signed [conv_pkg::RAM_WIDTH-1:0] o_data;

    modport master (
        output i_dato0, i_dato1, i_dato2, i_selecK_I, i_valid,
        input  o_data
    );

    modport slave (
        input  i_dato0, i_dato1, i_dato2, i_selecK_I, i_valid,
        output o_data
    );

endinterface

// File: rtl/bram_memory.sv
// bram_memory: simple dual-port RAM, 2^NB_ADDRESS x RAM_WIDTH.
//   i_CLK      - clock
//   i_wrEnable - synchronous write enable
//   i_writeAdd - write address
//   i_readAdd  - read address
//   i_data     - write data
//   o_data     - registered read data (one cycle after the address)
// A read of the address being written returns the old contents. No reset;
// contents power up as zero.
module bram_memory
    import conv_pkg::*;
(
    input  logic                  i_CLK,
    input  logic                  i_wrEnable,
    input  logic [NB_ADDRESS-1:0] i_writeAdd,
    input  logic [NB_ADDRESS-1:0] i_readAdd,
    input  logic [RAM_WIDTH-1:0]  i_data,
    output logic [RAM_WIDTH-1:0]  o_data
);

    logic [RAM_WIDTH-1:0] mem [2**NB_ADDRESS] = '{default: '0};
    logic [RAM_WIDTH-1:0] rd_q = '0;

    always_ff @(posedge i_CLK) begin
        if (i_wrEnable) begin
            mem[i_writeAdd] <= i_data;
        end
        rd_q <= mem[i_readAdd];
    end

    assign o_data = rd_q;

endmodule

// File: rtl/conv_mac3x3.sv
// conv_mac3x3: combinational 3x3 sum of products (correlation, no flip).
//   kernel - signed Q1.7 coefficients [col][row]
//   window - unsigned pixels [col][row], zero-extended before multiplying
//   acc    - signed CONV_LEN-bit sum; cannot overflow for any input
module conv_mac3x3
    import conv_pkg::*;
(
    input  kernel_t                     kernel,
    input  window_t                     window,
    output logic signed [CONV_LEN-1:0]  acc
);

    logic signed [PROD_LEN-1:0] prod [M_LEN][M_LEN];

    always_comb begin
        acc = '0;
        for (int c = 0; c < M_LEN; c++) begin
            for (int r = 0; r < M_LEN; r++) begin
                prod[c][r] = PROD_LEN'($signed(kernel[c][r]))
                           * PROD_LEN'($signed({1'b0, window[c][r]}));
                acc = acc + CONV_LEN'(prod[c][r]);
            end
        end
    end

endmodule

// File: rtl/conv.sv
// conv: streaming 3x3 convolution engine.
//   CLK100MHZ - clock, rising edge
//   i_reset   - asynchronous, active-low reset; zeroes kernel, window, output
//   bus       - conv_if slave: column stream in, registered sample out
// Kernel mode shifts a column into the kernel; image mode shifts a column
// into the window and, on the same edge, registers the result for the window
// as it stood before that edge.
module conv
    import conv_pkg::*;
(
    input  logic CLK100MHZ,
    input  logic i_reset,
    conv_if.slave bus
);

    kernel_t                    kernel;
    window_t                    window;
    logic signed [CONV_LEN-1:0] acc;
    logic                       unused_acc_lsb;

    conv_mac3x3 u_mac (
        .kernel (kernel),
        .window (window),
        .acc    (acc)
    );

    // Low accumulator bits are the Q1.7 fraction, dropped by the >>7 scaling.
    assign unused_acc_lsb = ^acc[CONV_LEN-CONV_LPOS-1:0];

    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            kernel     <= '0;
            window     <= '0;
            bus.o_data <= '0;
        end else if (bus.i_valid) begin
            if (!bus.i_selecK_I) begin
                kernel[0] <= kernel[1];
                kernel[1] <= kernel[2];
                kernel[2] <= {bus.i_dato2, bus.i_dato1, bus.i_dato0};
            end else begin
                window[0]  <= window[1];
                window[1]  <= window[2];
                window[2]  <= {bus.i_dato2, bus.i_dato1, bus.i_dato0};
                bus.o_data <= acc[CONV_LEN-1 -: CONV_LPOS];
            end
        end
    end

endmodule

// File: tb/tb_conv.sv
// tb_conv: self-checking bench for conv plus the bram_memory sibling.
module tb_conv;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv_if bus ();

    conv dut (
        .CLK100MHZ (clk),
        .i_reset   (rst_n),
        .bus       (bus)
    );

    logic                  m_we;
    logic [NB_ADDRESS-1:0] m_wa;
    logic [NB_ADDRESS-1:0] m_ra;
    logic [RAM_WIDTH-1:0]  m_wd;
    logic [RAM_WIDTH-1:0]  m_rd;

    bram_memory u_mem (
        .i_CLK      (clk),
        .i_wrEnable (m_we),
        .i_writeAdd (m_wa),
        .i_readAdd  (m_ra),
        .i_data     (m_wd),
        .o_data     (m_rd)
    );

    int total = 0;
    int bad   = 0;

    // Reference model, indexed [col][row].
    int mk [3][3];
    int mw [3][3];
    int mo;
    int exp_q [$];

    typedef struct {
        bit mode;
        bit valid;
        int d0;
        int d1;
        int d2;
        bit chk;
        int req;
    } vec_t;

    vec_t vt [$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int to_s8(input int d);
        logic signed [7:0] t;
        t = d[7:0];
        return int'(t);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) begin
                mk[c][r] = 0;
                mw[c][r] = 0;
            end
        mo = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit mode, input bit valid, input int d0, input int d1, input int d2);
        int acc;
        if (valid) begin
            if (!mode) begin
                for (int r = 0; r < 3; r++) begin
                    mk[0][r] = mk[1][r];
                    mk[1][r] = mk[2][r];
                end
                mk[2][0] = to_s8(d0);
                mk[2][1] = to_s8(d1);
                mk[2][2] = to_s8(d2);
            end else begin
                acc = 0;
                for (int c = 0; c < 3; c++)
                    for (int r = 0; r < 3; r++)
                        acc += mk[c][r] * mw[c][r];
                mo = acc >>> 7;
                exp_q.push_back(mo);
                for (int r = 0; r < 3; r++) begin
                    mw[0][r] = mw[1][r];
                    mw[1][r] = mw[2][r];
                end
                mw[2][0] = d0 & 255;
                mw[2][1] = d1 & 255;
                mw[2][2] = d2 & 255;
            end
        end
    endtask

    // One clock: drive at negedge, sample 1ns after the rising edge.
    task automatic drive(input bit mode, input bit valid, input int d0, input int d1, input int d2,
                         input string name, input bit chk, input int req);
        int d0v, d1v, d2v;
        @(negedge clk);
        d0v = d0; d1v = d1; d2v = d2;
        bus.i_selecK_I = mode;
        bus.i_valid    = valid;
        bus.i_dato0    = d0v[7:0];
        bus.i_dato1    = d1v[7:0];
        bus.i_dato2    = d2v[7:0];
        model_step(mode, valid, d0, d1, d2);
        @(posedge clk);
        #1;
        if (exp_q.size() != 0)
            check({name, "_sb"}, int'(bus.o_data), exp_q.pop_front());
        else
            check({name, "_hold"}, int'(bus.o_data), mo);
        if (chk)
            check(name, int'(bus.o_data), req);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_selecK_I = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_dato0    = '0;
        bus.i_dato1    = '0;
        bus.i_dato2    = '0;
        m_we = 1'b0; m_wa = '0; m_ra = '0; m_wd = '0;
        model_reset();

        #12;
        check("reset_out", int'(bus.o_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Centre tap, hold, resume, max positive, max negative.
        vt.push_back('{0, 1, 0,    0,    0,    0, 0});
        vt.push_back('{0, 1, 0,    'h40, 0,    0, 0});
        vt.push_back('{0, 1, 0,    0,    0,    1, 0});
        vt.push_back('{1, 1, 10,   20,   30,   1, 0});
        vt.push_back('{1, 1, 40,   50,   60,   1, 0});
        vt.push_back('{1, 1, 70,   80,   90,   1, 10});
        vt.push_back('{1, 1, 1,    1,    1,    1, 25});
        vt.push_back('{1, 0, 200,  201,  202,  1, 25});
        vt.push_back('{0, 0, 3,    4,    5,    1, 25});
        vt.push_back('{1, 0, 255,  0,    255,  1, 25});
        vt.push_back('{0, 0, 9,    8,    7,    1, 25});
        vt.push_back('{1, 0, 17,   18,   19,   1, 25});
        vt.push_back('{1, 1, 0,    0,    0,    1, 40});
        vt.push_back('{0, 1, 'h7F, 'h7F, 'h7F, 1, 40});
        vt.push_back('{0, 1, 'h7F, 'h7F, 'h7F, 1, 40});
        vt.push_back('{0, 1, 'h7F, 'h7F, 'h7F, 1, 40});
        vt.push_back('{1, 1, 255,  255,  255,  0, 0});
        vt.push_back('{1, 1, 255,  255,  255,  0, 0});
        vt.push_back('{1, 1, 255,  255,  255,  0, 0});
        vt.push_back('{1, 1, 255,  255,  255,  1, 2277});
        vt.push_back('{0, 1, 'h80, 'h80, 'h80, 1, 2277});
        vt.push_back('{0, 1, 'h80, 'h80, 'h80, 1, 2277});
        vt.push_back('{0, 1, 'h80, 'h80, 'h80, 1, 2277});
        vt.push_back('{1, 1, 255,  255,  255,  0, 0});
        vt.push_back('{1, 1, 255,  255,  255,  0, 0});
        vt.push_back('{1, 1, 255,  255,  255,  0, 0});
        vt.push_back('{1, 1, 255,  255,  255,  1, -2295});

        for (int i = 0; i < vt.size(); i++)
            drive(vt[i].mode, vt[i].valid, vt[i].d0, vt[i].d1, vt[i].d2,
                  $sformatf("vec%0d", i), vt[i].chk, vt[i].req);

        // Random kernel and stream with gaps and mode switches.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), "rnd_k", 1'b0, 0);
        for (int i = 0; i < 40; i++)
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0),
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), "rnd_s", 1'b0, 0);

        // Reset asserted between edges clears the output immediately.
        @(negedge clk);
        bus.i_selecK_I = 1'b1;
        bus.i_valid    = 1'b1;
        bus.i_dato0    = 8'd99;
        bus.i_dato1    = 8'd99;
        bus.i_dato2    = 8'd99;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", int'(bus.o_data), 0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_held", int'(bus.o_data), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b1, 200, 150, 250, "post_rst", 1'b1, 0);

        // bram_memory: initial zero, write/read, read-during-write old data.
        @(negedge clk);
        m_we = 1'b1; m_wa = 10'h005; m_wd = 13'h1ABC; m_ra = 10'h007;
        @(posedge clk); #1;
        check("mem_init", int'(m_rd), 0);
        @(negedge clk);
        m_we = 1'b0; m_ra = 10'h005;
        @(posedge clk); #1;
        check("mem_read", int'(m_rd), 'h1ABC);
        @(negedge clk);
        m_we = 1'b1; m_wa = 10'h005; m_wd = 13'h0001; m_ra = 10'h005;
        @(posedge clk); #1;
        check("mem_rdw_old", int'(m_rd), 'h1ABC);
        @(negedge clk);
        m_we = 1'b0;
        @(posedge clk); #1;
        check("mem_rdw_new", int'(m_rd), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
